// File: rtl/axil_master_gfi_pkg.sv
// rtl/axil_master_gfi_pkg.sv - shared widths, AXI response codes and FSM states for axil_master_gfi
package axil_master_gfi_pkg;

    localparam int DEF_ADRES_BIT = 32;
    localparam int DEF_VERI_BIT  = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,
        YAZ_AW_W = 3'd1,
        YAZ_B    = 3'd2,
        OKU_AR   = 3'd3,
        OKU_R    = 3'd4,
        YANIT    = 3'd5
    } durum_t;

endpackage

// File: rtl/axil_master_gfi.sv
// rtl/axil_master_gfi.sv - AXI4-Lite master running one transaction per command, one response beat each
module axil_master_gfi
    import axil_master_gfi_pkg::*;
#(
    parameter int ADRES_BIT = DEF_ADRES_BIT,
    parameter int VERI_BIT  = DEF_VERI_BIT
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,

    input  logic                    komut_gecerli,
    output logic                    komut_hazir,
    input  logic                    komut_yaz,
    input  logic [ADRES_BIT-1:0]    komut_adres,
    input  logic [VERI_BIT-1:0]     komut_veri,
    input  logic [VERI_BIT/8-1:0]   komut_strb,

    output logic                    veri_gecerli,
    input  logic                    veri_hazir,
    output logic [VERI_BIT-1:0]     veri,
    output logic                    veri_hata,

    output logic [ADRES_BIT-1:0]    AWADDR,
    output logic                    AWVALID,
    output logic [2:0]              AWPROT,
    input  logic                    AWREADY,

    output logic [VERI_BIT-1:0]     WDATA,
    output logic [VERI_BIT/8-1:0]   WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,

    input  logic                    BVALID,
    input  logic [1:0]              BRESP,
    output logic                    BREADY,

    output logic [ADRES_BIT-1:0]    ARADDR,
    output logic                    ARVALID,
    output logic [2:0]              ARPROT,
    input  logic                    ARREADY,

    input  logic [VERI_BIT-1:0]     RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    durum_t durum;
    logic   aw_bitti;
    logic   w_bitti;
    logic   aw_simdi;
    logic   w_simdi;

    assign komut_hazir = (durum == BOSTA) && ARESETn;
    assign AWPROT      = 3'b000;
    assign ARPROT      = 3'b000;

    // AW and W complete independently; "simdi" includes a handshake happening this cycle.
    always_comb begin
        aw_simdi = aw_bitti || (AWVALID && AWREADY);
        w_simdi  = w_bitti  || (WVALID && WREADY);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            durum        <= BOSTA;
            aw_bitti     <= 1'b0;
            w_bitti      <= 1'b0;
            AWADDR       <= '0;
            AWVALID      <= 1'b0;
            WDATA        <= '0;
            WSTRB        <= '0;
            WVALID       <= 1'b0;
            BREADY       <= 1'b0;
            ARADDR       <= '0;
            ARVALID      <= 1'b0;
            RREADY       <= 1'b0;
            veri_gecerli <= 1'b0;
            veri         <= '0;
            veri_hata    <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (komut_gecerli) begin
                        if (komut_yaz) begin
                            AWADDR   <= komut_adres;
                            WDATA    <= komut_veri;
                            WSTRB    <= komut_strb;
                            AWVALID  <= 1'b1;
                            WVALID   <= 1'b1;
                            aw_bitti <= 1'b0;
                            w_bitti  <= 1'b0;
                            durum    <= YAZ_AW_W;
                        end else begin
                            ARADDR  <= komut_adres;
                            ARVALID <= 1'b1;
                            durum   <= OKU_AR;
                        end
                    end
                end
                YAZ_AW_W: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    aw_bitti <= aw_simdi;
                    w_bitti  <= w_simdi;
                    if (aw_simdi && w_simdi) begin
                        BREADY <= 1'b1;
                        durum  <= YAZ_B;
                    end
                end
                YAZ_B: begin
                    if (BVALID) begin
                        BREADY       <= 1'b0;
                        veri         <= '0;
                        veri_hata    <= (BRESP != RESP_OKAY);
                        veri_gecerli <= 1'b1;
                        durum        <= YANIT;
                    end
                end
                OKU_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        durum   <= OKU_R;
                    end
                end
                OKU_R: begin
                    // Read data is forwarded even on SLVERR/DECERR.
                    if (RVALID) begin
                        RREADY       <= 1'b0;
                        veri         <= RDATA;
                        veri_hata    <= (RRESP != RESP_OKAY);
                        veri_gecerli <= 1'b1;
                        durum        <= YANIT;
                    end
                end
                YANIT: begin
                    if (veri_hazir) begin
                        veri_gecerli <= 1'b0;
                        durum        <= BOSTA;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master_gfi.sv
// tb/tb_axil_master_gfi.sv - scoreboard bench for axil_master_gfi against a memory-backed AXI4-Lite slave
`timescale 1ns/1ps
module tb_axil_master_gfi;
    import axil_master_gfi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        komut_gecerli, komut_hazir, komut_yaz;
    logic [31:0] komut_adres, komut_veri;
    logic [3:0]  komut_strb;
    logic        veri_gecerli, veri_hazir, veri_hata;
    logic [31:0] veri;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axil_master_gfi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .komut_gecerli(komut_gecerli), .komut_hazir(komut_hazir), .komut_yaz(komut_yaz),
        .komut_adres(komut_adres), .komut_veri(komut_veri), .komut_strb(komut_strb),
        .veri_gecerli(veri_gecerli), .veri_hazir(veri_hazir), .veri(veri), .veri_hata(veri_hata),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment rules: address region selects the response, unwritten words read a fixed pattern.
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        case (a[15:12])
            4'hE:    return RESP_SLVERR;
            4'hF:    return RESP_DECERR;
            default: return RESP_OKAY;
        endcase
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference model: word memory plus the expected response of each accepted command.
    logic [31:0] model_mem [logic [31:0]];
    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    typedef struct { logic [31:0] v; logic h; } exp_t;
    exp_t sb[$];

    int n_cmds = 0, n_wr = 0, n_resp = 0, n_bhs = 0;
    int last_resp_cyc = -100;

    // Slave configuration
    bit rnd = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit hz_rand = 0;
    int hz_dly = 0;
    int vg_cnt = 0;

    // ------------------------------------------------------------------ slave
    logic [31:0] slv_mem [logic [31:0]];
    initial begin
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit have_aw, have_w, have_ar;
        logic [31:0] s_awaddr, s_wdata, s_araddr, old;
        logic [3:0]  s_wstrb;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(negedge ACLK);
            aw_hs = ARESETn && AWVALID && AWREADY;
            w_hs  = ARESETn && WVALID && WREADY;
            b_hs  = ARESETn && BVALID && BREADY;
            ar_hs = ARESETn && ARVALID && ARREADY;
            r_hs  = ARESETn && RVALID && RREADY;
            if (aw_hs) begin
                s_awaddr = AWADDR; have_aw = 1; aw_cnt = 0;
                if (rnd) aw_dly = $urandom_range(0, 4);
            end else if (AWVALID) aw_cnt++;
            if (w_hs) begin
                s_wdata = WDATA; s_wstrb = WSTRB; have_w = 1; w_cnt = 0;
                if (rnd) w_dly = $urandom_range(0, 4);
            end else if (WVALID) w_cnt++;
            if (ar_hs) begin
                s_araddr = ARADDR; have_ar = 1; ar_cnt = 0;
                if (rnd) ar_dly = $urandom_range(0, 4);
            end else if (ARVALID) ar_cnt++;
            if (b_hs) n_bhs++;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                have_aw = 0; have_w = 0; have_ar = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
                continue;
            end
            if (b_hs) BVALID = 0;
            if (r_hs) RVALID = 0;
            if (have_aw && have_w && !BVALID) begin
                if (b_cnt >= b_dly) begin
                    old = slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : (s_awaddr ^ 32'hA5A5_5A5A);
                    slv_mem[s_awaddr] = apply_strb(old, s_wdata, s_wstrb);
                    BRESP = resp_of(s_awaddr); BVALID = 1;
                    have_aw = 0; have_w = 0; b_cnt = 0;
                    if (rnd) b_dly = $urandom_range(0, 3);
                end else b_cnt++;
            end
            if (have_ar && !RVALID) begin
                if (r_cnt >= r_dly) begin
                    RDATA = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : (s_araddr ^ 32'hA5A5_5A5A);
                    RRESP = resp_of(s_araddr); RVALID = 1;
                    have_ar = 0; r_cnt = 0;
                    if (rnd) r_dly = $urandom_range(0, 3);
                end else r_cnt++;
            end
            AWREADY = AWVALID && !have_aw && (aw_cnt >= aw_dly);
            WREADY  = WVALID && !have_w && (w_cnt >= w_dly);
            ARREADY = ARVALID && !have_ar && (ar_cnt >= ar_dly);
        end
    end

    // ------------------------------------------------- AXI source-side rules
    initial begin
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        forever begin
            @(negedge ACLK);
            if (ARESETn) begin
                if (p_awv && !p_awr) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
                if (p_awv && p_awr)  check("aw_drop", AWVALID, 1'b0);
                if (p_wv && !p_wr)   check("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, p_wstrb, p_wdata});
                if (p_wv && p_wr)    check("w_drop", WVALID, 1'b0);
                if (p_arv && !p_arr) check("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
                if (p_arv && p_arr)  check("ar_drop", ARVALID, 1'b0);
            end
            p_awv = ARESETn && AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
            p_wv  = ARESETn && WVALID;  p_wr  = WREADY;  p_wdata = WDATA; p_wstrb = WSTRB;
            p_arv = ARESETn && ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
        end
    end

    // ------------------------------------------------------ response monitor
    initial begin
        veri_hazir = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            if (hz_rand) veri_hazir = veri_gecerli && ($urandom_range(0, 2) == 0);
            else         veri_hazir = veri_gecerli && (vg_cnt >= hz_dly);
        end
    end

    initial begin
        logic p_vg, p_hz, p_h;
        logic [31:0] p_v;
        exp_t e;
        p_vg = 0; p_hz = 0; p_h = 0; p_v = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                vg_cnt = 0;
            end else begin
                if (p_vg && !p_hz) check("resp_hold", {veri_gecerli, veri_hata, veri}, {1'b1, p_h, p_v});
                if (veri_gecerli) begin
                    check("busy_hazir", komut_hazir, 1'b0);
                    vg_cnt++;
                end
                if (veri_gecerli && veri_hazir) begin
                    n_resp++;
                    last_resp_cyc = cyc;
                    vg_cnt = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("resp", {veri_hata, veri}, {e.h, e.v});
                    end
                end
            end
            p_vg = ARESETn && veri_gecerli; p_hz = veri_hazir; p_v = veri; p_h = veri_hata;
        end
    end

    // ------------------------------------------------------------ driver
    task automatic issue(input bit yaz, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int acc);
        exp_t e;
        komut_gecerli = 1; komut_yaz = yaz; komut_adres = a; komut_veri = d; komut_strb = s;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (komut_hazir) begin acc = cyc; break; end
        end
        if (acc < 0) begin
            check("accept_timeout", 1'b0, 1'b1);
        end else begin
            n_cmds++;
            if (yaz) begin
                n_wr++;
                model_mem[a] = apply_strb(model_read(a), d, s);
                e.v = 32'h0;
            end else begin
                e.v = model_read(a);
            end
            e.h = (resp_of(a) != RESP_OKAY);
            sb.push_back(e);
        end
        @(posedge ACLK); #1;
        komut_gecerli = 0; komut_yaz = $urandom; komut_adres = $urandom;
        komut_veri = $urandom; komut_strb = $urandom;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge ACLK);
            if (sb.size() == 0 && komut_hazir) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 1'b0, 1'b1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        repeat (60000) @(posedge ACLK);
        errors++;
        $display("FAIL watchdog: cycle budget exhausted");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ------------------------------------------------------------ main
    initial begin
        int acc, acc2, n;
        logic [31:0] a, d;
        komut_gecerli = 0; komut_yaz = 0; komut_adres = 0; komut_veri = 0; komut_strb = 0;
        ARESETn = 0;
        repeat (3) @(negedge ACLK);
        check("rst_hazir", komut_hazir, 1'b0);
        check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, veri_gecerli, veri_hata}, 7'b0);
        check("rst_addr", {AWADDR, ARADDR}, 64'h0);
        check("rst_data", {WDATA, veri}, 64'h0);
        check("rst_strb_prot", {WSTRB, AWPROT, ARPROT}, 10'h0);
        #2 ARESETn = 1;
        @(posedge ACLK); #1;
        check("post_rst_hazir", komut_hazir, 1'b1);

        // Zero-wait write latency
        issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, acc);
        check("wr_n1_valid", {AWVALID, WVALID}, 2'b11);
        check("wr_n1_addr", AWADDR, 32'h10);
        check("wr_n1_data", {WSTRB, WDATA}, {4'hF, 32'hDEAD_BEEF});
        @(posedge ACLK); #1;
        check("wr_n2_bready", BREADY, 1'b1);
        @(posedge ACLK); #1;
        check("wr_n3_resp", {veri_gecerli, veri_hata, veri}, {1'b1, 1'b0, 32'h0});
        check("wr_n3_cycle", cyc, acc + 3);
        wait_idle();

        // Zero-wait read latency
        issue(0, 32'h0000_0010, 32'h0, 4'h0, acc);
        check("rd_n1_ar", {ARVALID, ARADDR}, {1'b1, 32'h10});
        @(posedge ACLK); #1;
        check("rd_n2_rready", RREADY, 1'b1);
        @(posedge ACLK); #1;
        check("rd_n3_resp", {veri_gecerli, veri_hata, veri}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        wait_idle();

        // Read with ARREADY delayed three cycles
        issue(1, 32'h0000_0020, 32'h1234_5678, 4'hF, acc);
        wait_idle();
        ar_dly = 3;
        issue(0, 32'h0000_0020, 32'h0, 4'h0, acc);
        n = 0;
        while (ARVALID && n < 20) begin n++; @(posedge ACLK); #1; end
        check("ar_valid_cycles", n, 4);
        wait_idle();
        ar_dly = 0;

        // W four cycles after AW, then the reverse
        for (int k = 0; k < 2; k++) begin
            int na, nw;
            aw_dly = (k == 0) ? 0 : 4;
            w_dly  = (k == 0) ? 4 : 0;
            issue(1, 32'h30 + 4*k, 32'hCAFE_0000 + k, 4'b0101, acc);
            na = 0; nw = 0;
            for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
                na += AWVALID; nw += WVALID;
                @(posedge ACLK); #1;
            end
            check("aw_cycles", na, 1 + aw_dly);
            check("w_cycles", nw, 1 + w_dly);
            wait_idle();
        end
        aw_dly = 0; w_dly = 0;
        issue(0, 32'h30, 0, 0, acc);
        issue(0, 32'h34, 0, 0, acc);
        wait_idle();

        // Error responses
        issue(1, 32'h0000_E000, 32'hFFFF_FFFF, 4'hF, acc);
        issue(0, 32'h0000_E000, 32'h0, 4'h0, acc);
        issue(1, 32'h0000_F004, 32'h5555_AAAA, 4'hF, acc);
        issue(0, 32'h0000_F004, 32'h0, 4'h0, acc);
        wait_idle();

        // Slow veri_hazir with back-to-back commands
        hz_dly = 5;
        issue(1, 32'h40, 32'h0BAD_F00D, 4'hF, acc);
        issue(0, 32'h40, 32'h0, 4'h0, acc2);
        check("b2b_accept_1", acc2, last_resp_cyc + 1);
        issue(0, 32'h10, 32'h0, 4'h0, acc2);
        check("b2b_accept_2", acc2, last_resp_cyc + 1);
        wait_idle();
        hz_dly = 0;

        // Reset while AW/W are both still pending
        aw_dly = 10; w_dly = 10;
        a = 32'h50;
        issue(1, a, model_read(a), 4'hF, acc);
        @(posedge ACLK); #1;
        check("pre_rst_awvalid", {AWVALID, WVALID}, 2'b11);
        #2 ARESETn = 0;
        #1;
        check("mid_rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, veri_gecerli}, 6'b0);
        check("mid_rst_hazir", komut_hazir, 1'b0);
        sb.delete();
        n_cmds--; n_wr--;
        aw_dly = 0; w_dly = 0;
        @(posedge ACLK); @(posedge ACLK); #3 ARESETn = 1;
        @(negedge ACLK);
        check("rel_hazir", komut_hazir, 1'b1);
        n = 0;
        for (int i = 0; i < 5; i++) begin @(negedge ACLK); n += veri_gecerli; end
        check("no_resp_after_rst", n, 0);
        @(posedge ACLK); #1;
        issue(0, a, 32'h0, 4'h0, acc);
        wait_idle();

        // Randomised traffic
        rnd = 1; hz_rand = 1;
        for (int t = 0; t < 300; t++) begin
            int r;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge ACLK);
            #0;
            r = $urandom_range(0, 9);
            a = {16'h0, (r < 7) ? 4'h0 : ((r < 9) ? 4'hE : 4'hF), 6'h0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            issue($urandom_range(0, 1), a, d, 4'($urandom_range(0, 15)), acc);
        end
        wait_idle();

        check("resp_count", n_resp, n_cmds);
        check("b_handshakes", n_bhs, n_wr);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
